// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default datapath widths and the fetch FSM states.
package cpu_pkg;

    localparam int ADDRESS_WIDTH_DEFAULT    = 6;
    localparam int INSTRUCTION_SIZE_DEFAULT = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } fetchState_t;

endpackage

// File: rtl/inst_fifo.sv
// Prefetch buffer: circular FIFO of {instruction, pc} with a registered head entry.
// A flush empties it and wins over any push or pop in the same cycle.
module inst_fifo
    import cpu_pkg::*;
#(
    parameter int ADDRESS_WIDTH    = ADDRESS_WIDTH_DEFAULT,
    parameter int INSTRUCTION_SIZE = INSTRUCTION_SIZE_DEFAULT,
    parameter int DEPTH            = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_push,
    input  logic [INSTRUCTION_SIZE-1:0] i_pushInstr,
    input  logic [ADDRESS_WIDTH-1:0]    i_pushPc,
    input  logic                        i_pop,
    input  logic                        i_flush,
    output logic                        o_valid,
    output logic [INSTRUCTION_SIZE-1:0] o_instr,
    output logic [ADDRESS_WIDTH-1:0]    o_pc,
    output logic [$clog2(DEPTH):0]      o_level
);

    localparam int PW = $clog2(DEPTH);

    logic [INSTRUCTION_SIZE-1:0] r_memInstr [DEPTH];
    logic [ADDRESS_WIDTH-1:0]    r_memPc    [DEPTH];
    logic [PW-1:0]               r_rdPtr;
    logic [PW-1:0]               r_wrPtr;
    logic [PW:0]                 r_count;
    logic                        r_valid;
    logic [INSTRUCTION_SIZE-1:0] r_headInstr;
    logic [ADDRESS_WIDTH-1:0]    r_headPc;

    logic                        w_doPop;
    logic [PW-1:0]               w_rdNext;
    logic [PW:0]                 w_countNext;

    assign w_doPop     = i_pop && r_valid;
    assign w_rdNext    = r_rdPtr + PW'(w_doPop);
    assign w_countNext = r_count + (PW+1)'(i_push) - (PW+1)'(w_doPop);

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_memInstr[r_wrPtr] <= i_pushInstr;
            r_memPc[r_wrPtr]    <= i_pushPc;
        end
    end

    // The head register takes the pushed word directly when it becomes the only live entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdPtr     <= '0;
            r_wrPtr     <= '0;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_headInstr <= '0;
            r_headPc    <= '0;
        end else if (i_flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            if (i_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            r_rdPtr <= w_rdNext;
            r_count <= w_countNext;
            r_valid <= (w_countNext != '0);
            if (w_countNext != '0) begin
                if (i_push && (w_rdNext == r_wrPtr)) begin
                    r_headInstr <= i_pushInstr;
                    r_headPc    <= i_pushPc;
                end else begin
                    r_headInstr <= r_memInstr[w_rdNext];
                    r_headPc    <= r_memPc[w_rdNext];
                end
            end
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_headInstr;
    assign o_pc    = r_headPc;
    assign o_level = r_count;

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetcher: credit-limited sequential fetch into inst_fifo, with redirect flush
// that cancels the in-flight memory response.
module inst_prefetch
    import cpu_pkg::*;
#(
    parameter int ADDRESS_WIDTH    = ADDRESS_WIDTH_DEFAULT,
    parameter int INSTRUCTION_SIZE = INSTRUCTION_SIZE_DEFAULT,
    parameter int DEPTH            = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        imem_req,
    output logic [ADDRESS_WIDTH-1:0]    imem_addr,
    input  logic [INSTRUCTION_SIZE-1:0] imem_rdata,
    input  logic                        redirect,
    input  logic [ADDRESS_WIDTH-1:0]    redirect_pc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [INSTRUCTION_SIZE-1:0] out_instr,
    output logic [ADDRESS_WIDTH-1:0]    out_pc,
    output logic [$clog2(DEPTH):0]      level
);

    localparam int CW = $clog2(DEPTH) + 2;

    fetchState_t              r_state;
    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic                     r_active;
    logic                     r_inflight;
    logic [ADDRESS_WIDTH-1:0] r_inflightPc;

    logic [CW-1:0]            w_used;
    logic                     w_credit;
    logic                     w_issue;
    logic                     w_pop;

    // A request already in flight is counted as occupied so the buffer can never overflow.
    assign w_used   = CW'(level) + CW'(r_inflight);
    assign w_credit = w_used < CW'(DEPTH);
    assign w_issue  = r_active && (r_state != HOLD) && w_credit;
    assign w_pop    = out_valid && out_ready && !redirect;

    assign imem_req  = w_issue;
    assign imem_addr = r_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= FETCH;
            r_pc         <= '0;
            r_active     <= 1'b0;
            r_inflight   <= 1'b0;
            r_inflightPc <= '0;
        end else begin
            r_active <= 1'b1;
            if (redirect) begin
                r_state    <= FLUSH;
                r_pc       <= redirect_pc;
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_pc         <= r_pc + ADDRESS_WIDTH'(1);
                    r_inflightPc <= r_pc;
                end
                case (r_state)
                    FETCH:   if (!w_credit) r_state <= HOLD;
                    HOLD:    if (w_pop) r_state <= FETCH;
                    FLUSH:   r_state <= FETCH;
                    default: r_state <= FETCH;
                endcase
            end
        end
    end

    inst_fifo #(
        .ADDRESS_WIDTH    (ADDRESS_WIDTH),
        .INSTRUCTION_SIZE (INSTRUCTION_SIZE),
        .DEPTH            (DEPTH)
    ) uFifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_pushInstr (imem_rdata),
        .i_pushPc    (r_inflightPc),
        .i_pop       (w_pop),
        .i_flush     (redirect),
        .o_valid     (out_valid),
        .o_instr     (out_instr),
        .o_pc        (out_pc),
        .o_level     (level)
    );

endmodule

// File: tb/tb_inst_prefetch.sv
// Bench for inst_prefetch: directed scenarios load a scoreboard of expected fetch PCs,
// a negedge monitor pops and compares every instruction decode accepts.
module tb_inst_prefetch;

    localparam int AW    = 6;
    localparam int IW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          imemReq;
    logic [AW-1:0] imemAddr;
    logic [IW-1:0] imemRdata = '0;
    logic          redirect;
    logic [AW-1:0] redirectPc;
    logic          outValid;
    logic          outReady;
    logic [IW-1:0] outInstr;
    logic [AW-1:0] outPc;
    logic [2:0]    level;

    int            total = 0;
    int            bad   = 0;
    logic [AW-1:0] expQ [$];
    logic [AW-1:0] expPc;

    inst_prefetch #(
        .ADDRESS_WIDTH    (AW),
        .INSTRUCTION_SIZE (IW),
        .DEPTH            (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imemReq),
        .imem_addr   (imemAddr),
        .imem_rdata  (imemRdata),
        .redirect    (redirect),
        .redirect_pc (redirectPc),
        .out_valid   (outValid),
        .out_ready   (outReady),
        .out_instr   (outInstr),
        .out_pc      (outPc),
        .level       (level)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] memWord(input logic [AW-1:0] addr);
        return IW'(addr) * IW'(3);
    endfunction

    // Memory answers one cycle after the request; garbage when nothing was asked for.
    always @(posedge clk) begin
        if (imemReq) imemRdata <= memWord(imemAddr);
        else         imemRdata <= 32'hA5A5_A5A5;
    end

    task automatic checkOutput(input string name, input logic [IW-1:0] actual,
                               input logic [IW-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic doRedirect, input logic [AW-1:0] pc,
                                 input logic ready);
        redirect   = doRedirect;
        redirectPc = pc;
        outReady   = ready;
    endtask

    task automatic nextCycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic startStream(input logic [AW-1:0] first);
        expQ.delete();
        for (int i = 0; i < 60; i++) expQ.push_back(first + AW'(i));
    endtask

    task automatic waitLevel(input logic [2:0] target, input string name);
        int n = 0;
        @(negedge clk);
        while (level !== target && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, IW'(level), IW'(target));
    endtask

    always @(negedge clk) begin
        if (rst && outValid && outReady && !redirect) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected delivery: got pc %0h, expected none", outPc);
            end else begin
                expPc = expQ.pop_front();
                checkOutput("sb out_pc", IW'(outPc), IW'(expPc));
                checkOutput("sb out_instr", outInstr, memWord(expPc));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset imem_req", IW'(imemReq), 32'd0);
        checkOutput("reset imem_addr", IW'(imemAddr), 32'd0);
        checkOutput("reset out_valid", IW'(outValid), 32'd0);
        checkOutput("reset out_instr", outInstr, 32'd0);
        checkOutput("reset out_pc", IW'(outPc), 32'd0);
        checkOutput("reset level", IW'(level), 32'd0);

        // Streaming from reset release, decode always ready.
        startStream(6'h00);
        outReady = 1'b1;
        rst      = 1'b1;
        nextCycle(1);
        @(negedge clk);
        checkOutput("first req", IW'(imemReq), 32'd1);
        checkOutput("first addr", IW'(imemAddr), 32'd0);
        nextCycle(1);
        @(negedge clk);
        checkOutput("latency out_valid n+1", IW'(outValid), 32'd0);
        checkOutput("second addr", IW'(imemAddr), 32'd1);
        nextCycle(1);
        @(negedge clk);
        checkOutput("latency out_valid n+2", IW'(outValid), 32'd1);

        // Decode stalls for 10 cycles: buffer fills to 4 and fetch holds.
        nextCycle(5);
        applyStimulus(1'b0, '0, 1'b0);
        nextCycle(3);
        @(negedge clk);
        checkOutput("stall level", IW'(level), 32'd4);
        checkOutput("hold imem_req", IW'(imemReq), 32'd0);
        checkOutput("stall out_pc", IW'(outPc), 32'd5);
        checkOutput("stall out_valid", IW'(outValid), 32'd1);
        nextCycle(6);
        @(negedge clk);
        checkOutput("stall level late", IW'(level), 32'd4);
        checkOutput("hold imem_req late", IW'(imemReq), 32'd0);
        checkOutput("stable out_pc", IW'(outPc), 32'd5);
        nextCycle(1);
        applyStimulus(1'b0, '0, 1'b1);
        nextCycle(1);
        @(negedge clk);
        checkOutput("resume req", IW'(imemReq), 32'd1);
        checkOutput("resume addr", IW'(imemAddr), 32'd9);

        // Redirect to 0x20 with three buffered and one in flight.
        nextCycle(4);
        applyStimulus(1'b0, '0, 1'b0);
        waitLevel(3'd3, "pre-redirect level");
        startStream(6'h20);
        applyStimulus(1'b1, 6'h20, 1'b0);
        nextCycle(1);
        applyStimulus(1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("flush level", IW'(level), 32'd0);
        checkOutput("flush out_valid", IW'(outValid), 32'd0);
        checkOutput("flush req", IW'(imemReq), 32'd1);
        checkOutput("flush addr", IW'(imemAddr), 32'h20);
        nextCycle(1);
        @(negedge clk);
        checkOutput("dropped response level", IW'(level), 32'd0);
        nextCycle(1);
        @(negedge clk);
        checkOutput("redirect out_valid", IW'(outValid), 32'd1);
        checkOutput("redirect out_pc", IW'(outPc), 32'h20);

        // PC wrap from 0x3F to 0x00.
        nextCycle(3);
        startStream(6'h3C);
        applyStimulus(1'b1, 6'h3C, 1'b1);
        nextCycle(1);
        applyStimulus(1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("wrap flush out_valid", IW'(outValid), 32'd0);
        checkOutput("wrap flush addr", IW'(imemAddr), 32'h3C);
        nextCycle(3);
        @(negedge clk);
        checkOutput("wrap addr 3f", IW'(imemAddr), 32'h3F);
        nextCycle(1);
        @(negedge clk);
        checkOutput("wrap req", IW'(imemReq), 32'd1);
        checkOutput("wrap addr 00", IW'(imemAddr), 32'h00);

        // Back-to-back redirects: only 0x08 may be delivered.
        nextCycle(4);
        startStream(6'h08);
        applyStimulus(1'b1, 6'h10, 1'b1);
        nextCycle(1);
        applyStimulus(1'b1, 6'h08, 1'b1);
        nextCycle(1);
        applyStimulus(1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("b2b req", IW'(imemReq), 32'd1);
        checkOutput("b2b addr", IW'(imemAddr), 32'h08);
        nextCycle(2);
        @(negedge clk);
        checkOutput("b2b out_valid", IW'(outValid), 32'd1);
        checkOutput("b2b out_pc", IW'(outPc), 32'h08);

        // Asynchronous reset with two entries buffered.
        nextCycle(3);
        applyStimulus(1'b0, '0, 1'b0);
        waitLevel(3'd2, "pre-reset level");
        rst = 1'b0;
        startStream(6'h00);
        #1;
        checkOutput("async reset imem_req", IW'(imemReq), 32'd0);
        checkOutput("async reset imem_addr", IW'(imemAddr), 32'd0);
        checkOutput("async reset out_valid", IW'(outValid), 32'd0);
        checkOutput("async reset out_instr", outInstr, 32'd0);
        checkOutput("async reset out_pc", IW'(outPc), 32'd0);
        checkOutput("async reset level", IW'(level), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst      = 1'b1;
        outReady = 1'b1;
        nextCycle(1);
        @(negedge clk);
        checkOutput("restart req", IW'(imemReq), 32'd1);
        checkOutput("restart addr", IW'(imemAddr), 32'd0);
        nextCycle(2);
        @(negedge clk);
        checkOutput("restart out_valid", IW'(outValid), 32'd1);
        checkOutput("restart out_pc", IW'(outPc), 32'd0);
        checkOutput("restart out_instr", outInstr, 32'd0);

        nextCycle(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
